switch_debouncer: RTL

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer_pkg.sv | 21 ++
 rtl/switch_debouncer_bit.sv | 84 ++++++++
 rtl/switch_debouncer.sv | 46 ++++
 3 files changed

// File: rtl/switch_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// switch_debouncer_pkg
// Shared constants and helpers for the switch debouncer.
//   SW_WIDTH_DEF         : default number of switch bits (10)
//   DEBOUNCE_CYCLES_DEF  : default stable-level cycle count (50000, 1 ms @ 50 MHz)
//   cnt_width()          : width of the per-bit stability counter
// -----------------------------------------------------------------------------
package switch_debouncer_pkg;

   localparam int SW_WIDTH_DEF        = 10;
   localparam int DEBOUNCE_CYCLES_DEF = 50000;

   // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2(DEBOUNCE_CYCLES)
   // bits suffice; clamp to 1 so a degenerate parameter still elaborates.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Debounces one switch input: two-flop synchronizer, stability counter and
// (optionally) a registered one-cycle change pulse.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (builds the change pulse
// register; otherwise sw_change_o is tied low).
// Ports:
//   clk          : system clock
//   reset_n      : synchronous active-low reset
//   sw_raw_i     : asynchronous, bouncy switch level
//   sw_db_o      : debounced level
//   sw_change_o  : one-cycle pulse in the cycle sw_db_o takes a new value
// -----------------------------------------------------------------------------
module debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_raw_i,
   output logic sw_db_o,
   output logic sw_change_o
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges: the
   // counter climbs to CNT_MAX and the following mismatching edge accepts the
   // new level. Any edge where the level agrees again restarts the count.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_raw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sw_db_o = db_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
   logic change_q, change_d;

   // Registered alongside db_q so the pulse lines up with the new level.
   assign change_d = (db_d != db_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         change_q <= 1'b0;
      end else begin
         change_q <= change_d;
      end
   end

   assign sw_change_o = change_q;
`else
   assign sw_change_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Debounces WIDTH board switches independently for a PIO input port.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (per-bit change pulses and
// the combined 'changed' flag; otherwise both are tied low).
// Parameters:
//   WIDTH           : number of switch bits
//   DEBOUNCE_CYCLES : stable cycles required to accept a change (>= 2)
// Ports:
//   clk       : system clock
//   reset_n   : synchronous active-low reset
//   sw_raw    : asynchronous, bouncy switch levels
//   sw_db     : debounced levels
//   sw_change : per-bit one-cycle pulse when sw_db toggles
//   changed   : OR of sw_change
// -----------------------------------------------------------------------------
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_change,
   output logic             changed
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk        (clk),
         .reset_n    (reset_n),
         .sw_raw_i   (sw_raw[g]),
         .sw_db_o    (sw_db[g]),
         .sw_change_o(sw_change[g])
      );
   end

   // Every term is a flop output, so this is cycle-aligned with sw_change.
   assign changed = |sw_change;

endmodule
